// File: rtl/pcie_cpl_tx.sv
// Completion transmitter: one MRd in flight, single-beat CplD / UR / CA Cpl on Avalon-ST.
// Optional read timeout enabled by defining PCIE_CPL_TIMEOUT_EN (completes as CA).
module pcie_cpl_tx #(
    parameter int MAX_LEN_DW  = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [23:0]  req_trans_id,
    input  logic [2:0]   req_tc,
    input  logic [1:0]   req_attr,
    input  logic [9:0]   req_len,
    input  logic [6:0]   req_addr_lo,
    input  logic [3:0]   req_fbe,
    input  logic [3:0]   req_lbe,
    input  logic         req_ur,
    input  logic [15:0]  cpl_id,
    output logic         rd_req,
    input  logic         rd_data_valid,
    input  logic [63:0]  rd_data,
    input  logic         tx_st_ready,
    output logic         tx_st_valid,
    output logic         tx_st_sop,
    output logic         tx_st_eop,
    output logic [1:0]   tx_st_empty,
    output logic         tx_st_err,
    output logic [255:0] tx_st_data
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_SEND} state_t;

    localparam logic [2:0] ST_SC = 3'b000;
    localparam logic [2:0] ST_UR = 3'b001;
    localparam logic [2:0] ST_CA = 3'b100;

    state_t      state;
    logic        tx_valid;
    logic [23:0] r_tid;
    logic [2:0]  r_tc;
    logic [1:0]  r_attr;
    logic [9:0]  r_len;
    logic [6:0]  r_addr;
    logic [3:0]  r_fbe;
    logic [3:0]  r_lbe;
    logic [2:0]  r_status;
    logic [63:0] r_data;
    logic        unsup;

`ifdef PCIE_CPL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;
`endif

    assign unsup = req_ur || (req_len == 10'd0) ||
                   (req_len > 10'(MAX_LEN_DW));

    // Request/read/send sequencing with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            rd_req    <= 1'b0;
            tx_valid  <= 1'b0;
            r_tid     <= '0;
            r_tc      <= '0;
            r_attr    <= '0;
            r_len     <= '0;
            r_addr    <= '0;
            r_fbe     <= '0;
            r_lbe     <= '0;
            r_status  <= ST_SC;
            r_data    <= '0;
`ifdef PCIE_CPL_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        r_tid     <= req_trans_id;
                        r_tc      <= req_tc;
                        r_attr    <= req_attr;
                        r_len     <= req_len;
                        r_addr    <= req_addr_lo;
                        r_fbe     <= req_fbe;
                        r_lbe     <= req_lbe;
                        r_data    <= '0;
                        if (unsup) begin
                            r_status <= ST_UR;
                            tx_valid <= 1'b1;
                            state    <= S_SEND;
                        end else begin
                            r_status <= ST_SC;
                            rd_req   <= 1'b1;
                            state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    rd_req   <= 1'b0;
                    state    <= S_WAIT;
`ifdef PCIE_CPL_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (rd_data_valid) begin
                        r_data   <= rd_data;
                        tx_valid <= 1'b1;
                        state    <= S_SEND;
                    end
`ifdef PCIE_CPL_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        r_status <= ST_CA;
                        tx_valid <= 1'b1;
                        state    <= S_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_SEND: begin
                    if (tx_st_ready) begin
                        tx_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [2:0]  fz;
    logic [2:0]  lz;
    logic [11:0] bc_one;
    logic [11:0] byte_cnt;
    logic        is_cpld;
    logic [31:0] dw0, dw1, dw2, dw3, dw4;
    logic [1:0]  empty;

    // Disabled bytes before the first enabled one, and after the last
    always_comb begin
        fz = 3'd4;
        lz = 3'd4;
        casez (r_fbe)
            4'b???1: fz = 3'd0;
            4'b??10: fz = 3'd1;
            4'b?100: fz = 3'd2;
            4'b1000: fz = 3'd3;
            default: fz = 3'd4;
        endcase
        casez (r_lbe)
            4'b1???: lz = 3'd0;
            4'b01??: lz = 3'd1;
            4'b001?: lz = 3'd2;
            4'b0001: lz = 3'd3;
            default: lz = 3'd4;
        endcase
    end

    // Single-DW byte count from the first-DW enable pattern
    always_comb begin
        bc_one = 12'd1;
        casez (r_fbe)
            4'b1??1:          bc_one = 12'd4;
            4'b01?1, 4'b1?10: bc_one = 12'd3;
            4'b0011, 4'b0110,
            4'b1100:          bc_one = 12'd2;
            default:          bc_one = 12'd1;
        endcase
    end

    // Header and payload assembly from captured fields
    always_comb begin
        is_cpld  = (r_status == ST_SC);
        byte_cnt = (r_len == 10'd1) ? bc_one :
                   {r_len, 2'b00} - 12'(fz) - 12'(lz);
        dw0 = {1'b0, is_cpld ? 2'b10 : 2'b00, 5'b01010,
               1'b0, r_tc, 4'b0000, 1'b0, 1'b0, r_attr, 2'b00,
               is_cpld ? r_len : 10'd0};
        dw1 = {cpl_id, r_status, 1'b0, byte_cnt};
        dw2 = {r_tid, 1'b0, r_addr[6:2], r_addr[1:0] | fz[1:0]};
        dw3 = is_cpld ? r_data[31:0] : 32'd0;
        dw4 = (is_cpld && r_len == 10'd2) ? r_data[63:32] : 32'd0;
        empty = (is_cpld && r_len == 10'd2) ? 2'd1 : 2'd2;
    end

    assign tx_st_valid = tx_valid;
    assign tx_st_sop   = tx_valid;
    assign tx_st_eop   = tx_valid;
    assign tx_st_err   = 1'b0;
    assign tx_st_empty = tx_valid ? empty : 2'd0;
    assign tx_st_data  = tx_valid ?
                         {128'd0, dw4, dw3, dw2, dw1, dw0} : 256'd0;

endmodule

// File: tb/tb_pcie_cpl_tx.sv
// Randomized bench for pcie_cpl_tx against a behavioural completion model.
// Covers directed completion examples, UR, backpressure, reset abort and read timeout.
module tb_pcie_cpl_tx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [23:0]  req_trans_id;
    logic [2:0]   req_tc;
    logic [1:0]   req_attr;
    logic [9:0]   req_len;
    logic [6:0]   req_addr_lo;
    logic [3:0]   req_fbe;
    logic [3:0]   req_lbe;
    logic         req_ur;
    logic [15:0]  cpl_id;
    logic         rd_req;
    logic         rd_data_valid;
    logic [63:0]  rd_data;
    logic         tx_st_ready;
    logic         tx_st_valid;
    logic         tx_st_sop;
    logic         tx_st_eop;
    logic [1:0]   tx_st_empty;
    logic         tx_st_err;
    logic [255:0] tx_st_data;

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int beat_cnt = 0;

    pcie_cpl_tx dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_trans_id(req_trans_id), .req_tc(req_tc),
        .req_attr(req_attr), .req_len(req_len),
        .req_addr_lo(req_addr_lo), .req_fbe(req_fbe),
        .req_lbe(req_lbe), .req_ur(req_ur), .cpl_id(cpl_id),
        .rd_req(rd_req), .rd_data_valid(rd_data_valid),
        .rd_data(rd_data), .tx_st_ready(tx_st_ready),
        .tx_st_valid(tx_st_valid), .tx_st_sop(tx_st_sop),
        .tx_st_eop(tx_st_eop), .tx_st_empty(tx_st_empty),
        .tx_st_err(tx_st_err), .tx_st_data(tx_st_data)
    );

    always #5 clk = ~clk;

    // Independent event counters for read strobes and accepted beats
    always @(posedge clk) begin
        if (rd_req) rd_cnt <= rd_cnt + 1;
        if (tx_st_valid && tx_st_ready) beat_cnt <= beat_cnt + 1;
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_set(input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) return i;
        return 4;
    endfunction

    function automatic int last_set(input logic [3:0] be);
        for (int i = 3; i >= 0; i--) if (be[i]) return i;
        return -1;
    endfunction

    function automatic logic [2:0] model_status(input logic ur,
                                                input logic [9:0] len);
        if (ur || len == 0 || len > 2) return 3'b001;
        return 3'b000;
    endfunction

    // Expected TLP beat from PCIe completion rules
    function automatic logic [255:0] model_tlp(
        input logic [2:0] st, input logic [9:0] len,
        input logic [3:0] fbe, input logic [3:0] lbe,
        input logic [6:0] addr, input logic [2:0] tc,
        input logic [1:0] attr, input logic [23:0] tid,
        input logic [15:0] cid, input logic [63:0] d);
        logic [255:0] t;
        logic [31:0] dw0, dw1, dw2;
        int n_dw, bc, lo;
        bit cpld;
        cpld = (st == 3'b000);
        n_dw = (len == 0) ? 1024 : int'(len);
        if (n_dw == 1)
            bc = (fbe == 0) ? 1 : last_set(fbe) - first_set(fbe) + 1;
        else
            bc = n_dw * 4 - first_set(fbe) - (3 - last_set(lbe));
        bc = bc % 4096;
        lo = (fbe == 0) ? 0 : first_set(fbe);
        dw0 = cpld ? 32'h4A000000 : 32'h0A000000;
        dw0 = dw0 | (32'(tc) << 20) | (32'(attr) << 12);
        if (cpld) dw0 = dw0 | 32'(len);
        dw1 = (32'(cid) << 16) | (32'(st) << 13) | 32'(bc);
        dw2 = (32'(tid) << 8) | (32'(addr) & 32'h7C) | 32'(lo);
        t = '0;
        t[31:0]  = dw0;
        t[63:32] = dw1;
        t[95:64] = dw2;
        if (cpld) t[127:96] = d[31:0];
        if (cpld && len == 2) t[159:128] = d[63:32];
        return t;
    endfunction

    task automatic issue(input logic ur, input logic [9:0] len,
                         input logic [3:0] fbe, input logic [3:0] lbe,
                         input logic [6:0] addr, input logic [2:0] tc,
                         input logic [1:0] attr, input logic [23:0] tid);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin ok = 1; break; end
            tick();
        end
        check("req_ready_idle", 256'(ok), 256'd1);
        req_valid = 1'b1; req_ur = ur; req_len = len;
        req_fbe = fbe; req_lbe = lbe; req_addr_lo = addr;
        req_tc = tc; req_attr = attr; req_trans_id = tid;
        tick();
        req_valid = 1'b0;
        req_trans_id = 24'($urandom); req_len = 10'($urandom);
        req_fbe = 4'($urandom); req_ur = 1'($urandom);
        check("req_ready_busy", 256'(req_ready), 256'd0);
    endtask

    task automatic run_txn(input logic ur, input logic [9:0] len,
                           input logic [3:0] fbe, input logic [3:0] lbe,
                           input logic [6:0] addr, input logic [2:0] tc,
                           input logic [1:0] attr, input logic [23:0] tid,
                           input logic [63:0] d, input int lat,
                           input int stall, input bit junk);
        logic [255:0] exp;
        logic [2:0] st;
        int rd0, bt0;
        bit ok;
        st  = model_status(ur, len);
        exp = model_tlp(st, len, fbe, lbe, addr, tc, attr, tid, cpl_id, d);
        if (junk) begin
            rd_data_valid = 1'b1; rd_data = {$urandom, $urandom};
            tick();
            rd_data_valid = 1'b0;
        end
        rd0 = rd_cnt;
        bt0 = beat_cnt;
        issue(ur, len, fbe, lbe, addr, tc, attr, tid);
        if (st == 3'b000) begin
            ok = 0;
            for (int i = 0; i < 10; i++) begin
                if (rd_req) begin ok = 1; break; end
                tick();
            end
            check("rd_req_seen", 256'(ok), 256'd1);
            tick();
            check("rd_req_1cyc", 256'(rd_req), 256'd0);
            repeat (lat) tick();
            rd_data_valid = 1'b1; rd_data = d;
            tick();
            rd_data_valid = 1'b0; rd_data = {$urandom, $urandom};
        end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_st_valid) begin ok = 1; break; end
            tick();
        end
        check("tx_valid_seen", 256'(ok), 256'd1);
        check("tx_data", tx_st_data, exp);
        check("tx_empty", 256'(tx_st_empty),
              (st == 0 && len == 2) ? 256'd1 : 256'd2);
        check("tx_sop_eop_err", 256'({tx_st_sop, tx_st_eop, tx_st_err}),
              256'(3'b110));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("tx_hold", {tx_st_valid, tx_st_data[254:0]},
                  {1'b1, exp[254:0]});
        end
        tx_st_ready = 1'b1;
        tick();
        tx_st_ready = 1'b0;
        check("tx_done", 256'(tx_st_valid), 256'd0);
        check("rd_req_count", 256'(rd_cnt - rd0),
              256'((st == 0) ? 1 : 0));
        check("beat_count", 256'(beat_cnt - bt0), 256'd1);
    endtask

    initial begin
        int n;
        bit seen;
        logic [9:0] len;
        logic [3:0] fbe, lbe;
        rst_n = 1'b0; req_valid = 1'b0; req_trans_id = '0;
        req_tc = '0; req_attr = '0; req_len = '0; req_addr_lo = '0;
        req_fbe = '0; req_lbe = '0; req_ur = 1'b0; cpl_id = 16'h0100;
        rd_data_valid = 1'b0; rd_data = '0; tx_st_ready = 1'b0;
        repeat (3) tick();
        check("rst_outputs", 256'({req_ready, rd_req, tx_st_valid,
              tx_st_sop, tx_st_eop, tx_st_empty, tx_st_err}), 256'd0);
        check("rst_data", tx_st_data, 256'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 256'(req_ready), 256'd1);

        run_txn(0, 10'd1, 4'hF, 4'h0, 7'h10, 3'd0, 2'd0, 24'h000005,
                64'h01234567DEADBEEF, 0, 0, 0);
        check("ex1_dw0", 256'(32'h4A000001), 256'(exp_dw(0)));
        run_txn(0, 10'd1, 4'b0110, 4'h0, 7'h10, 3'd2, 2'd1, 24'h12345A,
                64'h55AA55AA_11223344, 2, 1, 0);
        run_txn(0, 10'd2, 4'hF, 4'b0011, 7'h24, 3'd7, 2'd3, 24'hABCDEF,
                64'hCAFEF00D_DEADBEEF, 1, 10, 1);
        run_txn(1, 10'd1, 4'hF, 4'h0, 7'h10, 3'd0, 2'd0, 24'h000005,
                64'h0, 0, 2, 0);
        run_txn(0, 10'd3, 4'hF, 4'hF, 7'h40, 3'd1, 2'd0, 24'h0F0F01,
                64'h1, 0, 0, 0);
        run_txn(0, 10'd0, 4'hF, 4'hF, 7'h00, 3'd0, 2'd2, 24'h000102,
                64'h2, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            len = ($urandom_range(0, 4) == 0) ? 10'($urandom) :
                  10'($urandom_range(1, 2));
            fbe = 4'($urandom);
            lbe = 4'($urandom);
            if (len > 1 && fbe == 0) fbe = 4'h8;
            if (len > 1 && lbe == 0) lbe = 4'h1;
            cpl_id = 16'($urandom);
            run_txn(($urandom_range(0, 4) == 0), len, fbe, lbe,
                    {5'($urandom), 2'b00}, 3'($urandom), 2'($urandom),
                    24'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 4), $urandom_range(0, 3),
                    1'($urandom));
        end

        cpl_id = 16'h0100;
        issue(0, 10'd1, 4'hF, 4'h0, 7'h10, 3'd0, 2'd0, 24'h000005);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs",
              256'({req_ready, rd_req, tx_st_valid}), 256'd0);
        tick();
        tick();
        rst_n = 1'b1;
        rd_data_valid = 1'b1; rd_data = 64'hBAD;
        tick();
        rd_data_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_st_valid) seen = 1;
            tick();
        end
        check("abort_no_tx", 256'(seen), 256'd0);
        check("abort_ready", 256'(req_ready), 256'd1);
        run_txn(0, 10'd1, 4'b1100, 4'h0, 7'h08, 3'd0, 2'd0, 24'h000077,
                64'h0000_0000_89ABCDEF, 0, 0, 0);

        issue(0, 10'd1, 4'hF, 4'h0, 7'h10, 3'd0, 2'd0, 24'h000005);
        tick();
        n = 0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx_st_valid) begin seen = 1; break; end
            tick();
            n++;
        end
`ifdef PCIE_CPL_TIMEOUT_EN
        check("timeout_seen", 256'(seen), 256'd1);
        check("timeout_cycles", 256'(n), 256'd255);
        check("timeout_dw0", 256'(tx_st_data[31:0]), 256'(32'h0A000000));
        check("timeout_dw1", 256'(tx_st_data[63:32]), 256'(32'h01008004));
        check("timeout_empty", 256'(tx_st_empty), 256'd2);
        tx_st_ready = 1'b1;
        tick();
        tx_st_ready = 1'b0;
        check("timeout_done", 256'(tx_st_valid), 256'd0);
`else
        check("no_timeout", 256'(seen), 256'd0);
        check("no_timeout_busy", 256'(req_ready), 256'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [31:0] exp_dw(input int i);
        logic [255:0] t;
        t = model_tlp(3'b000, 10'd1, 4'hF, 4'h0, 7'h10, 3'd0, 2'd0,
                      24'h000005, 16'h0100, 64'hDEADBEEF);
        return t[i*32 +: 32];
    endfunction

endmodule
